// File: rtl/boot_verifier.sv
// Boot image verifier: after bootstrap, reads back the slice, lookahead and control SRAMs byte by
// byte and compares each byte against the EEPROM source image, recording mismatches.
module boot_verifier #(
    parameter int unsigned SLICE_WORDS     = 65536,
    parameter int unsigned LOOKAHEAD_WORDS = 4096,
    parameter int unsigned CONTROL_WORDS   = 4096
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic        START,
    input  logic        N_BOOTED,
    output logic [16:0] EEPROM_ADDR,
    input  logic [7:0]  EEPROM_DATA,
    output logic [1:0]  SRAM_SEL,
    output logic [16:0] SRAM_ADDR,
    output logic        SRAM_N_OE,
    input  logic [7:0]  SRAM_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [16:0] ERR_ADDR,
    output logic [7:0]  ERR_COUNT
);

    typedef enum logic [1:0] {StIdle, StAddr, StSample, StFinish} state_e;

    localparam logic [1:0] RegSlice = 2'd0;
    localparam logic [1:0] RegLook  = 2'd1;
    localparam logic [1:0] RegCtrl  = 2'd2;
    localparam logic [1:0] RegNone  = 2'd3;

    state_e      state_q, state_d;
    logic [1:0]  region_q, region_d;
    logic [16:0] index_q, index_d;
    logic        error_q, error_d;
    logic [16:0] err_addr_q, err_addr_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        done_q, done_d;

    logic [16:0] cur_addr;
    logic [1:0]  next_region;

    // First non-empty region at or after 'from'; RegNone when none remain.
    function automatic logic [1:0] first_region(input logic [1:0] from);
        if (from == RegSlice && SLICE_WORDS != 0) return RegSlice;
        if (from <= RegLook && LOOKAHEAD_WORDS != 0) return RegLook;
        if (from <= RegCtrl && CONTROL_WORDS != 0) return RegCtrl;
        return RegNone;
    endfunction

    function automatic logic [16:0] region_base(input logic [1:0] r);
        case (r)
            RegLook: return 17'(SLICE_WORDS);
            RegCtrl: return 17'(SLICE_WORDS + LOOKAHEAD_WORDS);
            default: return 17'd0;
        endcase
    endfunction

    function automatic logic [16:0] region_last(input logic [1:0] r);
        case (r)
            RegSlice: return 17'(SLICE_WORDS - 1);
            RegLook:  return 17'(LOOKAHEAD_WORDS - 1);
            RegCtrl:  return 17'(CONTROL_WORDS - 1);
            default:  return 17'd0;
        endcase
    endfunction

    assign cur_addr    = region_base(region_q) + index_q;
    assign next_region = first_region(region_q + 2'd1);

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q     <= StIdle;
            region_q    <= RegSlice;
            index_q     <= 17'd0;
            error_q     <= 1'b0;
            err_addr_q  <= 17'd0;
            err_count_q <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            index_q     <= index_d;
            error_q     <= error_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        index_d     = index_q;
        error_d     = error_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        done_d      = done_q;
        EEPROM_ADDR = 17'd0;
        SRAM_SEL    = RegNone;
        SRAM_ADDR   = 17'd0;
        SRAM_N_OE   = 1'b1;
        BUSY        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START && !N_BOOTED) begin
                    error_d     = 1'b0;
                    err_addr_d  = 17'd0;
                    err_count_d = 8'd0;
                    done_d      = 1'b0;
                    region_d    = first_region(RegSlice);
                    index_d     = 17'd0;
                    state_d     = (first_region(RegSlice) == RegNone) ? StFinish : StAddr;
                end
            end
            StAddr, StSample: begin
                BUSY        = 1'b1;
                EEPROM_ADDR = cur_addr;
                SRAM_SEL    = region_q;
                SRAM_ADDR   = index_q;
                SRAM_N_OE   = 1'b0;
                if (N_BOOTED) begin
                    state_d = StIdle;
                end else if (state_q == StAddr) begin
                    state_d = StSample;
                end else begin
                    if (EEPROM_DATA != SRAM_DATA) begin
                        error_d = 1'b1;
                        if (!error_q) err_addr_d = cur_addr;
                        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    end
                    if (index_q == region_last(region_q)) begin
                        index_d  = 17'd0;
                        region_d = next_region;
                        state_d  = (next_region == RegNone) ? StFinish : StAddr;
                    end else begin
                        index_d = index_q + 17'd1;
                        state_d = StAddr;
                    end
                end
            end
            StFinish: begin
                BUSY    = 1'b1;
                done_d  = !N_BOOTED;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign DONE      = done_q;
    assign ERROR     = error_q;
    assign ERR_ADDR  = err_addr_q;
    assign ERR_COUNT = err_count_q;

endmodule

// File: tb/tb_boot_verifier.sv
// Bench for boot_verifier: small 4/2/2 image instance plus a 300/0/0 instance for saturation.
module tb_boot_verifier;

    logic        CLK = 1'b0;
    logic        N_RST, START, N_BOOTED;
    logic [16:0] EEPROM_ADDR, SRAM_ADDR, ERR_ADDR;
    logic [7:0]  EEPROM_DATA, SRAM_DATA, ERR_COUNT;
    logic [1:0]  SRAM_SEL;
    logic        SRAM_N_OE, BUSY, DONE, ERROR;

    logic        START2;
    logic [16:0] EEPROM_ADDR2, SRAM_ADDR2, ERR_ADDR2;
    logic [7:0]  EEPROM_DATA2, SRAM_DATA2, ERR_COUNT2;
    logic [1:0]  SRAM_SEL2;
    logic        SRAM_N_OE2, BUSY2, DONE2, ERROR2;

    int nchk = 0;
    int nerr = 0;

    logic [7:0] ee [8];
    logic [7:0] sl [4];
    logic [7:0] lk [2];
    logic [7:0] ct [2];

    always #5 CLK = ~CLK;

    boot_verifier #(.SLICE_WORDS(4), .LOOKAHEAD_WORDS(2), .CONTROL_WORDS(2)) dut (
        .CLK(CLK), .N_RST(N_RST), .START(START), .N_BOOTED(N_BOOTED),
        .EEPROM_ADDR(EEPROM_ADDR), .EEPROM_DATA(EEPROM_DATA), .SRAM_SEL(SRAM_SEL),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_N_OE(SRAM_N_OE), .SRAM_DATA(SRAM_DATA), .BUSY(BUSY),
        .DONE(DONE), .ERROR(ERROR), .ERR_ADDR(ERR_ADDR), .ERR_COUNT(ERR_COUNT)
    );

    boot_verifier #(.SLICE_WORDS(300), .LOOKAHEAD_WORDS(0), .CONTROL_WORDS(0)) dut2 (
        .CLK(CLK), .N_RST(N_RST), .START(START2), .N_BOOTED(N_BOOTED),
        .EEPROM_ADDR(EEPROM_ADDR2), .EEPROM_DATA(EEPROM_DATA2), .SRAM_SEL(SRAM_SEL2),
        .SRAM_ADDR(SRAM_ADDR2), .SRAM_N_OE(SRAM_N_OE2), .SRAM_DATA(SRAM_DATA2), .BUSY(BUSY2),
        .DONE(DONE2), .ERROR(ERROR2), .ERR_ADDR(ERR_ADDR2), .ERR_COUNT(ERR_COUNT2)
    );

    always_comb begin
        EEPROM_DATA = 8'h00;
        SRAM_DATA   = 8'h00;
        if (EEPROM_ADDR < 17'd8) EEPROM_DATA = ee[EEPROM_ADDR[2:0]];
        case (SRAM_SEL)
            2'd0: if (SRAM_ADDR < 17'd4) SRAM_DATA = sl[SRAM_ADDR[1:0]];
            2'd1: if (SRAM_ADDR < 17'd2) SRAM_DATA = lk[SRAM_ADDR[0]];
            2'd2: if (SRAM_ADDR < 17'd2) SRAM_DATA = ct[SRAM_ADDR[0]];
            default: SRAM_DATA = 8'h00;
        endcase
    end

    // Second image: every SRAM byte is the complement of its EEPROM byte.
    assign EEPROM_DATA2 = EEPROM_ADDR2[7:0];
    assign SRAM_DATA2   = ~SRAM_ADDR2[7:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: image byte i lives in slice 0..3, lookahead 4..5, control 6..7.
    function automatic logic [7:0] sram_byte(input int i);
        if (i < 4) return sl[i];
        if (i < 6) return lk[i - 4];
        return ct[i - 6];
    endfunction

    function automatic int exp_sel(input int i);
        return (i < 4) ? 0 : (i < 6) ? 1 : 2;
    endfunction

    function automatic int exp_idx(input int i);
        return (i < 4) ? i : (i < 6) ? i - 4 : i - 6;
    endfunction

    task automatic model(output int cnt, output int first);
        cnt   = 0;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            if (ee[i] != sram_byte(i)) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endtask

    task automatic load_matching();
        for (int i = 0; i < 8; i++) ee[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) sl[i] = ee[i];
        for (int i = 0; i < 2; i++) lk[i] = ee[4 + i];
        for (int i = 0; i < 2; i++) ct[i] = ee[6 + i];
    endtask

    function automatic logic [7:0] flip();
        return 8'($urandom_range(255, 1));
    endfunction

    task automatic run_pass(input int hold, output int busy_n, output int seq_bad);
        START = 1'b1;
        @(negedge CLK);
        busy_n  = 0;
        seq_bad = 0;
        while (BUSY && busy_n < 100) begin
            if (busy_n + 1 >= hold) START = 1'b0;
            if (busy_n < 16) begin
                if (EEPROM_ADDR !== 17'(busy_n / 2) || SRAM_SEL !== 2'(exp_sel(busy_n / 2)) ||
                    SRAM_ADDR !== 17'(exp_idx(busy_n / 2)) || SRAM_N_OE !== 1'b0)
                    seq_bad++;
            end else if (SRAM_SEL !== 2'd3 || SRAM_N_OE !== 1'b1) begin
                seq_bad++;
            end
            busy_n++;
            @(negedge CLK);
        end
        START = 1'b0;
    endtask

    task automatic pass_checks(input string tag, input int hold);
        int busy_n, seq_bad, cnt, first;
        model(cnt, first);
        run_pass(hold, busy_n, seq_bad);
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'd17);
        check({tag, ".sequence"}, 32'(seq_bad), 32'd0);
        check({tag, ".done"}, 32'(DONE), 32'd1);
        check({tag, ".error"}, 32'(ERROR), 32'(cnt > 0));
        check({tag, ".err_addr"}, 32'(ERR_ADDR), 32'(first));
        check({tag, ".err_count"}, 32'(ERR_COUNT), 32'(cnt));
        check({tag, ".idle_sel"}, 32'(SRAM_SEL), 32'd3);
        check({tag, ".idle_noe"}, 32'(SRAM_N_OE), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".busy"}, 32'(BUSY), 32'd0);
        check({tag, ".done"}, 32'(DONE), 32'd0);
        check({tag, ".error"}, 32'(ERROR), 32'd0);
        check({tag, ".err_addr"}, 32'(ERR_ADDR), 32'd0);
        check({tag, ".err_count"}, 32'(ERR_COUNT), 32'd0);
        check({tag, ".ee_addr"}, 32'(EEPROM_ADDR), 32'd0);
        check({tag, ".sram_addr"}, 32'(SRAM_ADDR), 32'd0);
        check({tag, ".sel"}, 32'(SRAM_SEL), 32'd3);
        check({tag, ".noe"}, 32'(SRAM_N_OE), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int j, n;
        N_RST    = 1'b0;
        START    = 1'b0;
        START2   = 1'b0;
        N_BOOTED = 1'b0;
        load_matching();
        #1;
        reset_checks("reset");
        @(negedge CLK);
        N_RST = 1'b1;
        @(negedge CLK);

        // Matching images
        pass_checks("match", 1);

        // START while not booted is ignored; DONE from the last pass survives
        N_BOOTED = 1'b1;
        START    = 1'b1;
        repeat (3) @(negedge CLK);
        check("nboot.busy", 32'(BUSY), 32'd0);
        check("nboot.noe", 32'(SRAM_N_OE), 32'd1);
        check("nboot.done", 32'(DONE), 32'd1);
        START    = 1'b0;
        N_BOOTED = 1'b0;
        @(negedge CLK);

        // Two corruptions, START held into the pass
        lk[1] = lk[1] ^ flip();
        ct[0] = ct[0] ^ flip();
        pass_checks("two_corrupt", 4);
        check("two_corrupt.addr5", 32'(ERR_ADDR), 32'd5);
        check("two_corrupt.count2", 32'(ERR_COUNT), 32'd2);

        // Random corruption patterns
        for (int k = 0; k < 3; k++) begin
            load_matching();
            for (int i = 0; i < 4; i++) if ($urandom_range(2, 0) == 0) sl[i] = sl[i] ^ flip();
            for (int i = 0; i < 2; i++) if ($urandom_range(2, 0) == 0) lk[i] = lk[i] ^ flip();
            for (int i = 0; i < 2; i++) if ($urandom_range(2, 0) == 0) ct[i] = ct[i] ^ flip();
            pass_checks("random", 1);
        end

        // Abort at byte 3 with an earlier slice mismatch
        load_matching();
        j     = $urandom_range(2, 0);
        sl[j] = sl[j] ^ flip();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        check("abort.at_byte3", 32'(EEPROM_ADDR), 32'd3);
        N_BOOTED = 1'b1;
        @(negedge CLK);
        check("abort.busy", 32'(BUSY), 32'd0);
        check("abort.done", 32'(DONE), 32'd0);
        check("abort.sel", 32'(SRAM_SEL), 32'd3);
        check("abort.noe", 32'(SRAM_N_OE), 32'd1);
        check("abort.error", 32'(ERROR), 32'd1);
        check("abort.err_addr", 32'(ERR_ADDR), 32'(j));
        check("abort.err_count", 32'(ERR_COUNT), 32'd1);
        N_BOOTED = 1'b0;
        @(negedge CLK);
        check("abort.stays_idle", 32'(BUSY), 32'd0);

        // Reset between edges mid-pass
        load_matching();
        sl[0] = sl[0] ^ flip();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_mid.pre_error", 32'(ERROR), 32'd1);
        #2 N_RST = 1'b0;
        #1;
        reset_checks("rst_mid");
        @(negedge CLK);
        N_RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_mid.waits", 32'(BUSY), 32'd0);
        sl[0] = ee[0];
        pass_checks("rst_rerun", 1);

        // Saturation on the 300-byte slice-only instance
        START2 = 1'b1;
        @(negedge CLK);
        START2 = 1'b0;
        n      = 0;
        while (BUSY2 && n < 2000) begin
            n++;
            @(negedge CLK);
        end
        check("sat.busy_cycles", 32'(n), 32'd601);
        check("sat.err_count", 32'(ERR_COUNT2), 32'd255);
        check("sat.err_addr", 32'(ERR_ADDR2), 32'd0);
        check("sat.error", 32'(ERROR2), 32'd1);
        check("sat.done", 32'(DONE2), 32'd1);
        check("sat.sel", 32'(SRAM_SEL2), 32'd3);
        check("sat.noe", 32'(SRAM_N_OE2), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/boot_verifier.md
BOOT_VERIFIER -- requirements
Module: boot_verifier

Interface
REQ-001 The parameter SLICE_WORDS SHALL default to 65536 and gives the byte count of the MLU slice SRAM image.
REQ-002 The parameter LOOKAHEAD_WORDS SHALL default to 4096 and gives the byte count of the MLU lookahead SRAM image.
REQ-003 The parameter CONTROL_WORDS SHALL default to 4096 and gives the byte count of the microcode SRAM image; the sum of the three SHALL be at most 131072.
REQ-004 The port CLK SHALL be an input, 1 bit wide, and is the single clock; all state changes on its rising edge.
REQ-005 The port N_RST SHALL be an input, 1 bit wide, and is the reset: asynchronous and active-low.
REQ-006 The port START SHALL be an input, 1 bit wide, and requests a verification pass.
REQ-007 The port N_BOOTED SHALL be an input, 1 bit wide; low means bootstrap is complete.
REQ-008 The port EEPROM_ADDR SHALL be an output, 17 bits wide, and is the source image address.
REQ-009 The port EEPROM_DATA SHALL be an input, 8 bits wide, and is the source image byte.
REQ-010 The port SRAM_SEL SHALL be an output, 2 bits wide: 0=slice, 1=lookahead, 2=control, 3=none.
REQ-011 The port SRAM_ADDR SHALL be an output, 17 bits wide, and is the region-relative SRAM address.
REQ-012 The port SRAM_N_OE SHALL be an output, 1 bit wide, and is the active-low read enable for the selected SRAM.
REQ-013 The port SRAM_DATA SHALL be an input, 8 bits wide, and is the readback byte.
REQ-014 The port BUSY SHALL be an output, 1 bit wide, and is high while a pass runs.
REQ-015 The port DONE SHALL be an output, 1 bit wide, and is high from the end of a pass until the next START.
REQ-016 The port ERROR SHALL be an output, 1 bit wide, and is sticky for the current pass; high when at least one mismatch was found.
REQ-017 The port ERR_ADDR SHALL be an output, 17 bits wide, and holds the EEPROM address of the first mismatch.
REQ-018 The port ERR_COUNT SHALL be an output, 8 bits wide, and is the mismatch count, saturating at 255.

Function
REQ-019 The block SHALL implement the states IDLE, ADDR, SAMPLE and FINISH.
- IDLE -> ADDR on START=1 and N_BOOTED=0.
- START while N_BOOTED=1 SHALL be ignored.
REQ-020 On the START transition the block SHALL clear ERROR, ERR_ADDR, ERR_COUNT and DONE, set the region to slice and set the index to 0.
REQ-021 In ADDR the block SHALL drive the following, and then go to SAMPLE:
- EEPROM_ADDR = region base + index (bases 0, SLICE_WORDS, SLICE_WORDS+LOOKAHEAD_WORDS);
- SRAM_SEL = region;
- SRAM_ADDR = index;
- SRAM_N_OE = 0.
REQ-022 In SAMPLE the addresses and SRAM_N_OE=0 SHALL be held, and EEPROM_DATA and SRAM_DATA SHALL be compared at the rising edge that ends SAMPLE.
REQ-023 On a mismatch:
- ERR_COUNT SHALL increment, saturating at 255;
- if ERROR was 0, ERR_ADDR SHALL capture EEPROM_ADDR;
- ERROR SHALL be set.
REQ-024 After the SAMPLE compare, the block SHALL step as follows:
- index = region size - 1: reset the index to 0 and advance the region (slice -> lookahead -> control);
- after the control region: go to FINISH;
- otherwise: increment the index and return to ADDR.
REQ-025 Each byte SHALL take exactly 2 cycles; the pass SHALL be 2*(SLICE_WORDS+LOOKAHEAD_WORDS+CONTROL_WORDS) cycles from the first ADDR to FINISH entry.
REQ-026 A region of size 0 SHALL be skipped with no cycles spent in it.
REQ-027 FINISH SHALL last 1 cycle, in which the block sets DONE=1, drives SRAM_N_OE=1 and SRAM_SEL=3, and returns to IDLE.
REQ-028 BUSY SHALL be 1 exactly in the ADDR, SAMPLE and FINISH states.
REQ-029 START asserted while BUSY SHALL be ignored.
REQ-030 START asserted in IDLE with DONE=1 SHALL begin a new pass as in REQ-020.
REQ-031 If N_BOOTED rises mid-pass, the block SHALL abort to IDLE on the next edge with DONE=0, ERROR and ERR_* retained, SRAM_N_OE=1 and SRAM_SEL=3.
REQ-032 In IDLE the block SHALL drive SRAM_N_OE=1, SRAM_SEL=3 and both address outputs to 0.

Reset
REQ-033 On N_RST low, the block SHALL immediately, independent of CLK:
- enter IDLE;
- drive BUSY=0, DONE=0, ERROR=0, ERR_ADDR=0, ERR_COUNT=0, EEPROM_ADDR=0, SRAM_ADDR=0, SRAM_SEL=3 and SRAM_N_OE=1.
REQ-034 Reset mid-pass SHALL discard all progress; after N_RST rises, the block SHALL wait for a new START.

Verification (bench parameters SLICE_WORDS=4, LOOKAHEAD_WORDS=2, CONTROL_WORDS=2)
REQ-035 The bench SHALL cover a matching images scenario: N_BOOTED=0, START pulse -> BUSY for 17 cycles, DONE=1, ERROR=0, ERR_COUNT=0; EEPROM_ADDR sequence 0..7; SRAM_SEL sequence 0,0,0,0,1,1,2,2.
REQ-036 The bench SHALL cover a two-corruption scenario: SRAM lookahead[1] and control[0] corrupted -> ERROR=1, ERR_ADDR=5, ERR_COUNT=2, DONE=1.
REQ-037 The bench SHALL cover a not-booted scenario: START with N_BOOTED=1 -> stays IDLE, BUSY=0, SRAM_N_OE=1.
REQ-038 The bench SHALL cover an abort scenario: N_BOOTED raised at byte 3 -> next edge IDLE, DONE=0, SRAM_SEL=3.
REQ-039 The bench SHALL cover a reset mid-pass scenario: N_RST pulsed low between edges -> outputs at reset values before the next CLK edge; a new START reruns the full pass cleanly.
REQ-040 The bench SHALL cover a saturation scenario: SLICE_WORDS=300 with all bytes mismatched -> ERR_COUNT=255, ERR_ADDR=0.
